// File: rtl/aes_pkg.sv
// AES-128 shared definitions: GF(2^8) arithmetic, S-boxes, Rcon and the decrypt FSM states.
// S-boxes come from the field inverse plus affine map, so no 256-entry tables to maintain.
package aes_pkg;

   typedef enum logic [1:0] {IDLE, KEYEXP, DEC, DONE} state_t;

   localparam logic [7:0] RCON [16] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 = a^-1 for nonzero a, and maps 0 to 0 as the S-box requires
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gmul(sq, sq);
         acc = gmul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] i;
      i = gf_inv(a);
      return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
// Purely combinational; no handshake.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] rkey,
   input  logic         last,
   output logic [127:0] next_state
);

   logic [7:0] s [16];
   logic [7:0] a [16];
   logic [7:0] m [16];

   always_comb begin
      next_state = '0;
      for (int i = 0; i < 16; i++) begin
         s[i] = state[127-8*i -: 8];
      end
      // byte 4c+r takes row r from column (c-r) mod 4
      for (int i = 0; i < 16; i++) begin
         a[i] = inv_sbox(s[4*(((i/4) - (i%4)) & 3) + (i%4)]) ^ rkey[127-8*i -: 8];
      end
      for (int c = 0; c < 4; c++) begin
         m[4*c+0] = gmul(a[4*c], 8'h0e) ^ gmul(a[4*c+1], 8'h0b) ^ gmul(a[4*c+2], 8'h0d) ^ gmul(a[4*c+3], 8'h09);
         m[4*c+1] = gmul(a[4*c], 8'h09) ^ gmul(a[4*c+1], 8'h0e) ^ gmul(a[4*c+2], 8'h0b) ^ gmul(a[4*c+3], 8'h0d);
         m[4*c+2] = gmul(a[4*c], 8'h0d) ^ gmul(a[4*c+1], 8'h09) ^ gmul(a[4*c+2], 8'h0e) ^ gmul(a[4*c+3], 8'h0b);
         m[4*c+3] = gmul(a[4*c], 8'h0b) ^ gmul(a[4*c+1], 8'h0d) ^ gmul(a[4*c+2], 8'h09) ^ gmul(a[4*c+3], 8'h0e);
      end
      for (int i = 0; i < 16; i++) begin
         next_state[127-8*i -: 8] = last ? a[i] : m[i];
      end
   end

endmodule

// File: rtl/key_expansion.sv
// One forward AES-128 key-schedule step: round key k(count-1) -> k(count).
// Purely combinational; no handshake.
module key_expansion
   import aes_pkg::*;
(
   input  logic [127:0] key_in,
   input  logic [3:0]   count,
   output logic [127:0] key_out
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] t, n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = key_in;
   assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {RCON[count], 24'h000000};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;
   assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: 10 forward key-expansion cycles, then 10 inverse rounds (20 cycles/block).
// One block in flight; result held in DONE until out_ready, in_ready high only in IDLE.
module aes_decrypt_iter
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] data_in,
   input  logic [127:0] key,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [127:0] data_out,
   output logic         out_valid,
   input  logic         out_ready
);

   state_t       fsm_state;
   logic [127:0] blk;
   logic [127:0] rkey;
   logic [3:0]   cnt;
   logic [127:0] rkey_fwd;
   logic [127:0] rkey_prev;
   logic [127:0] round_out;
   logic         last_round;

   key_expansion u_key_expansion (
      .key_in  (rkey),
      .count   (cnt),
      .key_out (rkey_fwd)
   );

   // Inverse key step: k(cnt) -> k(cnt-1), undoing the forward word chain
   logic [31:0] w0, w1, w2, w3;
   logic [31:0] p0, p1, p2, p3;

   assign {w0, w1, w2, w3} = rkey;
   assign p3 = w3 ^ w2;
   assign p2 = w2 ^ w1;
   assign p1 = w1 ^ w0;
   assign p0 = w0 ^ sub_word({p3[23:0], p3[31:24]}) ^ {RCON[cnt], 24'h000000};
   assign rkey_prev  = {p0, p1, p2, p3};
   assign last_round = (cnt == 4'd1);

   aes_inv_round u_inv_round (
      .state      (blk),
      .rkey       (rkey_prev),
      .last       (last_round),
      .next_state (round_out)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_state <= IDLE;
         blk       <= '0;
         rkey      <= '0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         data_out  <= '0;
      end else begin
         case (fsm_state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  blk       <= data_in;
                  rkey      <= key;
                  cnt       <= 4'd1;
                  in_ready  <= 1'b0;
                  fsm_state <= KEYEXP;
               end
            end
            KEYEXP: begin
               rkey <= rkey_fwd;
               if (cnt == 4'd10) begin
                  blk       <= blk ^ rkey_fwd;
                  fsm_state <= DEC;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DEC: begin
               blk  <= round_out;
               rkey <= rkey_prev;
               cnt  <= cnt - 4'd1;
               if (last_round) begin
                  data_out  <= round_out;
                  out_valid <= 1'b1;
                  fsm_state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  fsm_state <= IDLE;
               end
            end
            default: fsm_state <= IDLE;
         endcase
      end
   end

endmodule
